branch_tracker: RTL and testbench
=================================

# branch_tracker

Tracks every fetched instruction's BTB prediction from IF until its branch outcome resolves, then produces the BTB update stream (`is_branch`/`is_taken`/`id_pc`/`alt_address`) and a front-end flush/redirect on misprediction. Sits between the BTB's lookup output and the resolution stage: it consumes `hit`/`alt_pc` at fetch time and drives the BTB's update port at resolve time. An in-order FIFO of in-flight predictions is used, so the BTB's update port receives correctly aligned PCs regardless of pipeline depth.

## Interface
- `DEPTH`, 8: in-flight entries; power of two, 2..16.
- `clk`  in  1  clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `stall`  in  1  freezes all state; no push, no pop.
- `if_valid`  in  1  IF presents an instruction this cycle.
- `if_pc`  in  32  fetched PC.
- `pred_hit`  in  1  BTB hit for `if_pc` (predicted taken).
- `pred_pc`  in  32  BTB predicted target.
- `res_valid`  in  1  resolution stage presents outcome of the oldest in-flight instruction.
- `res_is_branch`  in  1  resolved instruction is a branch/jump.
- `res_taken`  in  1  branch actually taken.
- `res_target`  in  32  actual taken target.
- `upd_is_branch`  out  1  to BTB `is_branch`; registered pulse.
- `upd_taken`  out  1  to BTB `is_taken`; registered.
- `upd_pc`  out  32  to BTB `id_pc`; registered.
- `upd_target`  out  32  to BTB `alt_address`; registered.
- `flush`  out  1  one-cycle pulse: discard wrong-path fetches.
- `redirect_pc`  out  32  fetch restart PC, valid when `flush`=1.
- `full`  out  1  count == DEPTH; IF must stall.
- `empty`  out  1  count == 0.
- `overflow`  out  1  sticky: push attempted while full without pop.
- `mispredict_count`  out  16  saturating mispredict counter.

## Operation
- Entry = {pc[31:0], hit, pred_pc[31:0]}; circular buffer, read/write pointers log2(DEPTH) bits wrapping at DEPTH, count log2(DEPTH)+1 bits.
- push = `if_valid & !stall`; pop = `res_valid & !stall & !empty`.
- Push while full: if pop also occurs same cycle, push succeeds (count unchanged); otherwise entry dropped, `overflow` set until reset.
- `res_valid` while empty: ignored, no outputs.
- On pop, with P = entry.hit, A = `res_is_branch & res_taken`:
  - P=1, A=0: mispredict, redirect = entry.pc + 4 (mod 2^32).
  - P=0, A=1: mispredict, redirect = `res_target`.
  - P=1, A=1, entry.pred_pc != `res_target`: mispredict, redirect = `res_target`.
  - otherwise correct; no flush.
- Mispredict: buffer cleared (pointers and count to 0) at the pop edge; any same-cycle push is discarded and not counted as overflow; `mispredict_count` +1, holds at 16'hFFFF.
- Every pop loads `upd_is_branch`=`res_is_branch`, `upd_taken`=`res_taken`, `upd_pc`=entry.pc, `upd_target`=`res_target`; non-pop cycles drive `upd_is_branch`=0, `upd_taken`=0 (PC/target hold).

## Timing
- Reset: all outputs 0 except `empty`=1; pointers, count, sticky, counter 0. Reset mid-operation drops all entries immediately.
- Push at edge T; entry poppable from cycle T+1 (no same-cycle bypass).
- Pop at edge T; `upd_*`, `flush`, `redirect_pc` valid during cycle T+1 only.
- `full`/`empty` combinational from count, reflect state after last edge.
- `stall` cycle: no state change; pulses present before the stall still last exactly one cycle.
- Back-to-back pops allowed every cycle; flush pulses may be consecutive only if pushes arrive between them.

## Test plan
- Reset, then push pc=0x100 hit=0; pop with branch=0 -> next cycle `upd_is_branch`=0, `flush`=0, `empty`=1.
- Push pc=0x200 hit=1 pred=0x400; pop branch=1 taken=1 target=0x400 -> `upd_is_branch`=1, `upd_taken`=1, `upd_pc`=0x200, `upd_target`=0x400, no flush.
- Push 0x300 hit=1 pred=0x500, push 0x304; pop taken=0 -> `flush`=1, `redirect_pc`=0x304, `empty`=1 next cycle, `mispredict_count`=1.
- Push 0xFFFFFFFC hit=1; resolve not-taken -> `redirect_pc`=0x00000000 (wrap).
- Fill DEPTH=8 entries; 9th push with no pop -> `full`=1, `overflow`=1, count stays 8; push+pop same cycle while full -> count 8, `overflow` unchanged.
- Hold `stall`=1 with `if_valid`/`res_valid` high for 3 cycles -> no count change, no pulses; assert `reset` mid-stream -> all outputs to reset values asynchronously.

Source files
------------

// File: rtl/branch_tracker.sv
// branch_tracker
// Holds each fetched instruction's BTB prediction in an in-order FIFO until
// the resolution stage reports its outcome. It then drives the BTB update
// port and, on a misprediction, flushes the front end with a restart PC.
//
// Ports:
//   clk, reset          clock and asynchronous active-high reset
//   stall               freezes all state (no push, no pop)
//   if_valid/if_pc      instruction fetched this cycle
//   pred_hit/pred_pc    BTB prediction for if_pc
//   res_valid/res_*     outcome of the oldest in-flight instruction
//   upd_*               registered BTB update (is_branch/is_taken pulses)
//   flush/redirect_pc   one-cycle flush pulse and fetch restart PC
//   full/empty          FIFO occupancy flags
//   overflow            sticky: a push was dropped because the FIFO was full
//   mispredict_count    saturating count of mispredictions
module branch_tracker #(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        if_valid,
  input  logic [31:0] if_pc,
  input  logic        pred_hit,
  input  logic [31:0] pred_pc,
  input  logic        res_valid,
  input  logic        res_is_branch,
  input  logic        res_taken,
  input  logic [31:0] res_target,
  output logic        upd_is_branch,
  output logic        upd_taken,
  output logic [31:0] upd_pc,
  output logic [31:0] upd_target,
  output logic        flush,
  output logic [31:0] redirect_pc,
  output logic        full,
  output logic        empty,
  output logic        overflow,
  output logic [15:0] mispredict_count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  logic [31:0] pc_mem   [DEPTH];
  logic        hit_mem  [DEPTH];
  logic [31:0] pred_mem [DEPTH];

  logic [PW-1:0] wr_q, wr_d;
  logic [PW-1:0] rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic [15:0]   mcnt_q, mcnt_d;

  logic        upd_is_branch_q, upd_taken_q, flush_q;
  logic [31:0] upd_pc_q, upd_target_q, redirect_q;

  logic        push, pop, do_write;
  logic        head_hit, actual_taken, mispredict;
  logic [31:0] head_pc, head_pred, redirect_d;

  assign full  = (cnt_q == CW'(DEPTH));
  assign empty = (cnt_q == '0);

  assign push = if_valid & ~stall;
  assign pop  = res_valid & ~stall & ~empty;

  assign head_pc      = pc_mem[rd_q];
  assign head_hit     = hit_mem[rd_q];
  assign head_pred    = pred_mem[rd_q];
  assign actual_taken = res_is_branch & res_taken;

  // Wrong direction either way, or right direction but wrong target.
  assign mispredict = (head_hit ^ actual_taken) |
                      (head_hit & actual_taken & (head_pred != res_target));

  // Predicted taken but fell through: restart at the sequential PC.
  assign redirect_d = (head_hit & ~actual_taken) ? (head_pc + 32'd4) : res_target;

  // A mispredict empties the FIFO and swallows any same-cycle push, so the
  // wrong-path fetch neither enters the buffer nor counts as overflow.
  always_comb begin
    wr_d     = wr_q;
    rd_d     = rd_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    mcnt_d   = mcnt_q;
    do_write = 1'b0;
    if (pop && mispredict) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
      if (mcnt_q != 16'hFFFF) mcnt_d = mcnt_q + 16'd1;
    end else begin
      if (pop) rd_d = rd_q + PW'(1);
      if (push && (!full || pop)) begin
        do_write = 1'b1;
        wr_d     = wr_q + PW'(1);
      end else if (push) begin
        ovf_d = 1'b1;
      end
      if (do_write && !pop)      cnt_d = cnt_q + CW'(1);
      else if (!do_write && pop) cnt_d = cnt_q - CW'(1);
    end
  end

  // Entry storage needs no reset: the pointers and count decide validity.
  always_ff @(posedge clk) begin
    if (do_write) begin
      pc_mem[wr_q]   <= if_pc;
      hit_mem[wr_q]  <= pred_hit;
      pred_mem[wr_q] <= pred_pc;
    end
  end

  // Pulses are recomputed every cycle (pop is already gated by stall), so
  // they last exactly one cycle even when a stall follows them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q            <= '0;
      rd_q            <= '0;
      cnt_q           <= '0;
      ovf_q           <= 1'b0;
      mcnt_q          <= '0;
      upd_is_branch_q <= 1'b0;
      upd_taken_q     <= 1'b0;
      upd_pc_q        <= '0;
      upd_target_q    <= '0;
      flush_q         <= 1'b0;
      redirect_q      <= '0;
    end else begin
      wr_q            <= wr_d;
      rd_q            <= rd_d;
      cnt_q           <= cnt_d;
      ovf_q           <= ovf_d;
      mcnt_q          <= mcnt_d;
      upd_is_branch_q <= pop & res_is_branch;
      upd_taken_q     <= pop & res_taken;
      flush_q         <= pop & mispredict;
      if (pop) begin
        upd_pc_q     <= head_pc;
        upd_target_q <= res_target;
      end
      if (pop && mispredict) redirect_q <= redirect_d;
    end
  end

  assign upd_is_branch    = upd_is_branch_q;
  assign upd_taken        = upd_taken_q;
  assign upd_pc           = upd_pc_q;
  assign upd_target       = upd_target_q;
  assign flush            = flush_q;
  assign redirect_pc      = redirect_q;
  assign overflow         = ovf_q;
  assign mispredict_count = mcnt_q;

endmodule

// File: tb/tb_branch_tracker.sv
// tb_branch_tracker
// Drives directed scenarios followed by randomized traffic into
// branch_tracker and compares every output, every cycle, against a
// queue-based reference model of the in-flight prediction list.
module tb_branch_tracker;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        if_valid;
  logic [31:0] if_pc;
  logic        pred_hit;
  logic [31:0] pred_pc;
  logic        res_valid;
  logic        res_is_branch;
  logic        res_taken;
  logic [31:0] res_target;
  logic        upd_is_branch;
  logic        upd_taken;
  logic [31:0] upd_pc;
  logic [31:0] upd_target;
  logic        flush;
  logic [31:0] redirect_pc;
  logic        full;
  logic        empty;
  logic        overflow;
  logic [15:0] mispredict_count;

  int testsRun  = 0;
  int failCount = 0;

  typedef struct {
    logic [31:0] pc;
    logic        hit;
    logic [31:0] pred;
  } entry_t;

  entry_t      inflight[$];
  logic        eIsBr, eTaken, eFlush, eOvf;
  logic [31:0] ePc, eTgt, eRedir;
  int          eMcnt;

  branch_tracker #(.DEPTH(DEPTH)) dut (
    .clk              (clk),
    .reset            (reset),
    .stall            (stall),
    .if_valid         (if_valid),
    .if_pc            (if_pc),
    .pred_hit         (pred_hit),
    .pred_pc          (pred_pc),
    .res_valid        (res_valid),
    .res_is_branch    (res_is_branch),
    .res_taken        (res_taken),
    .res_target       (res_target),
    .upd_is_branch    (upd_is_branch),
    .upd_taken        (upd_taken),
    .upd_pc           (upd_pc),
    .upd_target       (upd_target),
    .flush            (flush),
    .redirect_pc      (redirect_pc),
    .full             (full),
    .empty            (empty),
    .overflow         (overflow),
    .mispredict_count (mispredict_count)
  );

  always #5 clk = ~clk;

  // Single comparison point: every check is counted here.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testsRun++;
    if (obs !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic modelReset();
    inflight.delete();
    eIsBr = 0; eTaken = 0; eFlush = 0; eOvf = 0;
    ePc = 0; eTgt = 0; eRedir = 0; eMcnt = 0;
  endtask

  task automatic checkAll(input string where);
    checkOutput({where, ".upd_is_branch"}, {31'd0, upd_is_branch}, {31'd0, eIsBr});
    checkOutput({where, ".upd_taken"}, {31'd0, upd_taken}, {31'd0, eTaken});
    checkOutput({where, ".upd_pc"}, upd_pc, ePc);
    checkOutput({where, ".upd_target"}, upd_target, eTgt);
    checkOutput({where, ".flush"}, {31'd0, flush}, {31'd0, eFlush});
    checkOutput({where, ".redirect_pc"}, redirect_pc, eRedir);
    checkOutput({where, ".full"}, {31'd0, full}, {31'd0, inflight.size() == DEPTH});
    checkOutput({where, ".empty"}, {31'd0, empty}, {31'd0, inflight.size() == 0});
    checkOutput({where, ".overflow"}, {31'd0, overflow}, {31'd0, eOvf});
    checkOutput({where, ".mispredict_count"}, {16'd0, mispredict_count}, 32'(eMcnt));
  endtask

  // One clock cycle: drive inputs, advance the model from the rules, check.
  task automatic applyStimulus(input string where, input logic st,
                               input logic iv, input logic [31:0] ipc,
                               input logic hit, input logic [31:0] ppc,
                               input logic rv, input logic rb, input logic rt,
                               input logic [31:0] rtgt);
    bit doPush, doPop, predTaken, actTaken, mis;
    entry_t head;
    stall = st; if_valid = iv; if_pc = ipc; pred_hit = hit; pred_pc = ppc;
    res_valid = rv; res_is_branch = rb; res_taken = rt; res_target = rtgt;

    doPush = iv && !st;
    doPop  = rv && !st && (inflight.size() != 0);
    eIsBr  = doPop && rb;
    eTaken = doPop && rt;
    eFlush = 0;
    if (doPop) begin
      head      = inflight[0];
      ePc       = head.pc;
      eTgt      = rtgt;
      predTaken = head.hit;
      actTaken  = rb && rt;
      mis = 0;
      if (predTaken && !actTaken) begin
        mis = 1; eRedir = head.pc + 32'd4;
      end else if (!predTaken && actTaken) begin
        mis = 1; eRedir = rtgt;
      end else if (predTaken && actTaken && head.pred != rtgt) begin
        mis = 1; eRedir = rtgt;
      end
      if (mis) begin
        eFlush = 1;
        inflight.delete();
        if (eMcnt < 65535) eMcnt++;
      end else begin
        void'(inflight.pop_front());
        if (doPush) inflight.push_back('{pc: ipc, hit: hit, pred: ppc});
      end
    end else if (doPush) begin
      if (inflight.size() < DEPTH) inflight.push_back('{pc: ipc, hit: hit, pred: ppc});
      else eOvf = 1;
    end

    @(posedge clk);
    #1;
    checkAll(where);
  endtask

  task automatic idle(input string where);
    applyStimulus(where, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic doReset();
    reset = 1'b1;
    modelReset();
    @(posedge clk);
    #1;
    checkAll("reset");
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; stall = 0; if_valid = 0; if_pc = 0; pred_hit = 0; pred_pc = 0;
    res_valid = 0; res_is_branch = 0; res_taken = 0; res_target = 0;
    modelReset();
    #1;
    checkAll("reset_async");
    doReset();

    // Non-branch resolves cleanly.
    applyStimulus("push100", 0, 1, 32'h100, 0, 0, 0, 0, 0, 0);
    applyStimulus("pop100", 0, 0, 0, 0, 0, 1, 0, 0, 0);
    // Correctly predicted taken branch.
    applyStimulus("push200", 0, 1, 32'h200, 1, 32'h400, 0, 0, 0, 0);
    applyStimulus("pop200", 0, 0, 0, 0, 0, 1, 1, 1, 32'h400);
    // Predicted taken, not taken: restart at pc+4, buffer cleared.
    applyStimulus("push300", 0, 1, 32'h300, 1, 32'h500, 0, 0, 0, 0);
    applyStimulus("push304", 0, 1, 32'h304, 0, 0, 0, 0, 0, 0);
    applyStimulus("pop300", 0, 0, 0, 0, 0, 1, 1, 0, 32'h500);
    idle("after_flush");
    // Sequential PC wraps to zero.
    applyStimulus("pushFFC", 0, 1, 32'hFFFF_FFFC, 1, 32'h40, 0, 0, 0, 0);
    applyStimulus("popFFC", 0, 0, 0, 0, 0, 1, 1, 0, 0);
    // Wrong target on a taken prediction, then resolve while empty.
    applyStimulus("pushTgt", 0, 1, 32'h600, 1, 32'h700, 0, 0, 0, 0);
    applyStimulus("popTgt", 0, 0, 0, 0, 0, 1, 1, 1, 32'h704);
    applyStimulus("popEmpty", 0, 0, 0, 0, 0, 1, 1, 1, 32'h800);

    // Fill, overflow, then push+pop while full.
    for (int i = 0; i < DEPTH; i++)
      applyStimulus("fill", 0, 1, 32'h1000 + 32'(i * 4), 0, 0, 0, 0, 0, 0);
    applyStimulus("push9", 0, 1, 32'h2000, 0, 0, 0, 0, 0, 0);
    applyStimulus("pushPopFull", 0, 1, 32'h2004, 0, 0, 1, 0, 0, 0);

    // Stall with everything requested, right after a pulse-producing pop.
    applyStimulus("popBeforeStall", 0, 0, 0, 0, 0, 1, 1, 0, 32'h10);
    for (int i = 0; i < 3; i++)
      applyStimulus("stall", 1, 1, 32'h3000, 1, 32'h3100, 1, 1, 1, 32'h3100);

    // Reset mid-stream takes effect before the next clock edge.
    #2 reset = 1'b1;
    modelReset();
    #1;
    checkAll("midReset");
    @(posedge clk);
    #1;
    reset = 1'b0;
    checkAll("midResetHeld");

    // Randomized traffic in phases: push-heavy, pop-heavy, balanced.
    for (int c = 0; c < 1500; c++) begin
      int pushPct, popPct;
      logic [31:0] rpc;
      case ((c / 100) % 3)
        0: begin pushPct = 85; popPct = 20; end
        1: begin pushPct = 30; popPct = 80; end
        default: begin pushPct = 60; popPct = 60; end
      endcase
      rpc = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : {$urandom()} & 32'hFFFF_FFFC;
      applyStimulus("rand",
                    $urandom_range(0, 9) == 0,
                    $urandom_range(0, 99) < pushPct,
                    rpc,
                    1'($urandom_range(0, 1)),
                    32'($urandom_range(0, 3)) << 4,
                    $urandom_range(0, 99) < popPct,
                    $urandom_range(0, 3) != 0,
                    1'($urandom_range(0, 1)),
                    32'($urandom_range(0, 3)) << 4);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
